// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields into a 32-bit instruction word behind one valid/ready register stage,
// tagging each word with a sequential imem address. Define INSTR_ENC_CHECK_EN for range/opcode checks.
module instr_encoder #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    input  logic              err_clr,
    output logic              err_range,
    output logic              err_opcode
);

    localparam logic [6:0] OP_ARITH_I = 7'b0010011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_ARITH_R = 7'b0110011;

    logic              out_valid_q, out_valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       packed_word;
    logic              accept;
    logic              handshake;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign handshake = out_valid_q && out_ready;

    // Immediate bits above each format's field are simply dropped here.
    always_comb begin
        packed_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        case (in_opcode)
            OP_ARITH_I, OP_LOAD, OP_JALR:
                packed_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            OP_STORE:
                packed_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            OP_BRANCH:
                packed_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                               in_imm[4:1], in_imm[11], in_opcode};
            OP_LUI, OP_AUIPC:
                packed_word = {in_imm[31:12], in_rd, in_opcode};
            OP_JAL:
                packed_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            default: ;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        instr_d     = instr_q;
        addr_d      = addr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            instr_d     = packed_word;
        end else if (handshake) begin
            out_valid_d = 1'b0;
        end
        if (handshake) begin
            addr_d = addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            addr_q      <= BASE_ADDR;
        end else begin
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            addr_q      <= addr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = instr_q;
    assign out_addr  = addr_q;

`ifdef INSTR_ENC_CHECK_EN
    logic range_bad;
    logic opcode_bad;
    logic err_range_q, err_range_d;
    logic err_opcode_q, err_opcode_d;

    // A run of identical upper bits means the value sign-extends cleanly from the field width.
    always_comb begin
        range_bad  = 1'b0;
        opcode_bad = 1'b0;
        case (in_opcode)
            OP_ARITH_I, OP_LOAD, OP_JALR, OP_STORE:
                range_bad = !((&in_imm[31:11]) || !(|in_imm[31:11]));
            OP_BRANCH:
                range_bad = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
            OP_JAL:
                range_bad = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
            OP_LUI, OP_AUIPC:
                range_bad = |in_imm[11:0];
            OP_ARITH_R: ;
            default:
                opcode_bad = 1'b1;
        endcase
    end

    // A new error on the accept edge wins over a simultaneous clear.
    always_comb begin
        err_range_d  = err_clr ? 1'b0 : err_range_q;
        err_opcode_d = err_clr ? 1'b0 : err_opcode_q;
        if (accept && range_bad)  err_range_d  = 1'b1;
        if (accept && opcode_bad) err_opcode_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_range_q  <= 1'b0;
            err_opcode_q <= 1'b0;
        end else begin
            err_range_q  <= err_range_d;
            err_opcode_q <= err_opcode_d;
        end
    end

    assign err_range  = err_range_q;
    assign err_opcode = err_opcode_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_range      = 1'b0;
    assign err_opcode     = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: vector table for packing, hand sequences for
// backpressure, error flags (INSTR_ENC_CHECK_EN builds), address wrap and async reset.
module tb_instr_encoder;

`ifdef INSTR_ENC_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [7:0]  out_addr;
    logic        err_clr = 1'b0;
    logic        err_range, err_opcode;
    logic        w_in_ready, w_out_valid, w_err_range, w_err_opcode;
    logic [31:0] w_out_instr;
    logic [1:0]  w_out_addr;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .err_clr(err_clr), .err_range(err_range), .err_opcode(err_opcode)
    );

    instr_encoder #(.ADDR_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_instr(w_out_instr),
        .out_addr(w_out_addr), .err_clr(err_clr), .err_range(w_err_range), .err_opcode(w_err_opcode)
    );

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] instr;
        logic        rng;
        logic        opc;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
        in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        err_clr  = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset out_instr", out_instr, 32'd0);
        check("reset out_addr", {24'b0, out_addr}, 32'd0);
        check("reset err_range", {31'b0, err_range}, 32'd0);
        check("reset err_opcode", {31'b0, err_opcode}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t tmp;

    initial begin
        //           op          rd     rs1    rs2    f3    f7       imm            instr         rng   opc
        vecs[0]  = '{7'b0010011, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'hFFFFFFFF, 32'hFFF00093, 1'b0, 1'b0};
        vecs[1]  = '{7'b0100011, 5'd0,  5'd3,  5'd2,  3'd2, 7'h00, 32'h00000008, 32'h0021A423, 1'b0, 1'b0};
        vecs[2]  = '{7'b1101111, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000800, 32'h001000EF, 1'b0, 1'b0};
        vecs[3]  = '{7'b1100011, 5'd0,  5'd1,  5'd2,  3'd0, 7'h00, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0, 1'b0};
        vecs[4]  = '{7'b0110111, 5'd5,  5'd0,  5'd0,  3'd0, 7'h00, 32'h12345000, 32'h123452B7, 1'b0, 1'b0};
        vecs[5]  = '{7'b0110011, 5'd3,  5'd1,  5'd2,  3'd0, 7'h20, 32'h00000000, 32'h402081B3, 1'b0, 1'b0};
        vecs[6]  = '{7'b1100111, 5'd0,  5'd1,  5'd0,  3'd0, 7'h00, 32'h00000000, 32'h00008067, 1'b0, 1'b0};
        vecs[7]  = '{7'b0000011, 5'd5,  5'd2,  5'd0,  3'd2, 7'h00, 32'hFFFFFFF8, 32'hFF812283, 1'b0, 1'b0};
        vecs[8]  = '{7'b0010111, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'hFFFFF000, 32'hFFFFF097, 1'b0, 1'b0};
        vecs[9]  = '{7'b1101111, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'hFFFFFFFE, 32'hFFFFF06F, 1'b0, 1'b0};
        vecs[10] = '{7'b1111111, 5'd0,  5'd0,  5'd0,  3'd0, 7'h01, 32'h00000000, 32'h0200007F, 1'b0, 1'b1};
        vecs[11] = '{7'b0100011, 5'd0,  5'd1,  5'd5,  3'd0, 7'h00, 32'hFFFFFFFF, 32'hFE508FA3, 1'b0, 1'b0};
        vecs[12] = '{7'b0110111, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00001234, 32'h000010B7, 1'b1, 1'b0};

        // Table: one word per cycle with out_ready high; err_clr held so each flag reflects only its vector.
        do_reset();
        out_ready = 1'b1;
        err_clr   = 1'b1;
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            $display("[TB] vec %0d op %b -> instr %h addr %0d", i, vecs[i].op, out_instr, out_addr);
            check("vec out_valid", {31'b0, out_valid}, 32'd1);
            check("vec out_instr", out_instr, vecs[i].instr);
            check("vec out_addr", {24'b0, out_addr}, i);
            check("vec err_range", {31'b0, err_range}, {31'b0, CHECK & vecs[i].rng});
            check("vec err_opcode", {31'b0, err_opcode}, {31'b0, CHECK & vecs[i].opc});
        end
        @(negedge clk);
        in_valid = 1'b0;
        err_clr  = 1'b0;
        @(posedge clk);
        #1;
        check("drain out_valid", {31'b0, out_valid}, 32'd0);
        check("drain out_addr", {24'b0, out_addr}, NV);

        // Backpressure: second word must wait while the first is held stable.
        do_reset();
        out_ready = 1'b0;
        @(negedge clk);
        drive(vecs[0]);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("bp first out_valid", {31'b0, out_valid}, 32'd1);
        check("bp first instr", out_instr, 32'hFFF00093);
        @(negedge clk);
        drive(vecs[1]);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            $display("[TB] stall %0d instr %h in_ready %0d", c, out_instr, in_ready);
            check("bp held instr", out_instr, 32'hFFF00093);
            check("bp in_ready", {31'b0, in_ready}, 32'd0);
            check("bp held addr", {24'b0, out_addr}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp second instr", out_instr, 32'h0021A423);
        check("bp second addr", {24'b0, out_addr}, 32'd1);
        check("bp second valid", {31'b0, out_valid}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bp idle valid", {31'b0, out_valid}, 32'd0);
        check("bp idle addr", {24'b0, out_addr}, 32'd2);

        // Error flags: ADDI imm=2048, sticky hold, clear, branch odd offset, set-wins, bad opcode.
        do_reset();
        out_ready = 1'b1;
        tmp = '{7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000800, 32'h0, 1'b0, 1'b0};
        @(negedge clk);
        drive(tmp);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("imm2048 instr", out_instr, 32'h80000093);
        check("imm2048 err_range", {31'b0, err_range}, {31'b0, CHECK});
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("sticky err_range", {31'b0, err_range}, {31'b0, CHECK});
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        check("clr err_range", {31'b0, err_range}, 32'd0);
        tmp = '{7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000003, 32'h0, 1'b0, 1'b0};
        @(negedge clk);
        err_clr = 1'b0;
        drive(tmp);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("branch3 instr", out_instr, 32'h00000163);
        check("branch3 err_range", {31'b0, err_range}, {31'b0, CHECK});
        tmp = '{7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00001000, 32'h0, 1'b0, 1'b0};
        @(negedge clk);
        err_clr = 1'b1;
        drive(tmp);
        @(posedge clk);
        #1;
        check("set wins err_range", {31'b0, err_range}, {31'b0, CHECK});
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("clr2 err_range", {31'b0, err_range}, 32'd0);
        tmp = '{7'b1111111, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 32'h0, 1'b0, 1'b0};
        @(negedge clk);
        err_clr = 1'b0;
        drive(tmp);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("badop err_opcode", {31'b0, err_opcode}, {31'b0, CHECK});
        check("badop err_range", {31'b0, err_range}, 32'd0);

        // Address wrap on the 2-bit instance, then async reset while a word is held.
        do_reset();
        out_ready = 1'b1;
        drive(vecs[0]);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            $display("[TB] wrap %0d addr2 %0d addr8 %0d", i, w_out_addr, out_addr);
            check("wrap addr2", {30'b0, w_out_addr}, i % 4);
            check("wrap addr8", {24'b0, out_addr}, i);
        end
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", {31'b0, out_valid}, 32'd0);
        check("async rst w_out_valid", {31'b0, w_out_valid}, 32'd0);
        check("async rst out_addr", {24'b0, out_addr}, 32'd0);
        check("async rst w_out_addr", {30'b0, w_out_addr}, 32'd0);
        check("async rst out_instr", out_instr, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post rst out_valid", {31'b0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
